// File: rtl/schommel_besturing_pkg.sv
// rtl/schommel_besturing_pkg.sv - shared types, widths and helpers for the cradle rocking controller
package schommel_besturing_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        DECIDE,
        RAMP,
        ALARM
    } state_t;

    localparam int FREQ_W = 2;
    localparam int AMP_W  = 3;
    localparam int CNT_W  = 8;

    localparam logic [AMP_W-1:0]  AMP_MAX  = 3'd7;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 2'd3;

    // Calm/fail counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/schommel_pwm.sv
// rtl/schommel_pwm.sv - motor PWM generator and swing direction toggler
module schommel_pwm
    import schommel_besturing_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk12,
    input  logic              en,
    input  logic [FREQ_W-1:0] freq,
    input  logic [AMP_W-1:0]  amp,
    output logic              pwm,
    output logic              dir
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] thr;
    logic [2:0]          dir_cnt;
    logic [2:0]          dir_last;

    assign thr      = PWM_BITS'(amp) << (PWM_BITS - AMP_W);
    assign dir_last = 3'd3 - 3'(freq);

    // >= rather than == so a freq step mid-count never skips a toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pwm     <= 1'b0;
            dir     <= 1'b0;
            dir_cnt <= '0;
        end else begin
            cnt <= cnt + PWM_BITS'(1);
            pwm <= en && (cnt < thr);
            if (!en) begin
                dir     <= 1'b0;
                dir_cnt <= '0;
            end else if (clk12) begin
                if (dir_cnt >= dir_last) begin
                    dir     <= ~dir;
                    dir_cnt <= '0;
                end else begin
                    dir_cnt <= dir_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/schommel_besturing.sv
// rtl/schommel_besturing.sv - closed-loop cradle rocking controller top
module schommel_besturing
    import schommel_besturing_pkg::*;
#(
    parameter int EVAL_TICKS   = 8,
    parameter int CALM_WINDOWS = 3,
    parameter int MAX_FAIL     = 4,
    parameter int PWM_BITS     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk12,
    input  logic              start,
    input  logic              stop,
    input  logic              gedaald,
    input  logic              gelijk,
    output logic [FREQ_W-1:0] freq,
    output logic [AMP_W-1:0]  amp,
    output logic              motor_en,
    output logic              motor_pwm,
    output logic              motor_dir,
    output logic              alarm
);

    localparam int TICK_W = $clog2(EVAL_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(EVAL_TICKS - 1);
    localparam logic [CNT_W-1:0]  CALM_LIM  = CNT_W'(CALM_WINDOWS);
    localparam logic [CNT_W-1:0]  FAIL_LIM  = CNT_W'(MAX_FAIL);

    state_t             state, state_nxt;
    logic [FREQ_W-1:0]  freq_nxt, prev_freq, prev_freq_nxt;
    logic [AMP_W-1:0]   amp_nxt, prev_amp, prev_amp_nxt;
    logic               en_nxt, alarm_nxt;
    logic [TICK_W-1:0]  tick_cnt, tick_nxt;
    logic               seen_dal, seen_nxt;
    logic               gelijk_s, gelijk_nxt;
    logic [CNT_W-1:0]   calm_cnt, calm_nxt, calm_inc;
    logic [CNT_W-1:0]   fail_cnt, fail_nxt, fail_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            freq      <= '0;
            amp       <= '0;
            prev_freq <= '0;
            prev_amp  <= '0;
            motor_en  <= 1'b0;
            alarm     <= 1'b0;
            tick_cnt  <= '0;
            seen_dal  <= 1'b0;
            gelijk_s  <= 1'b0;
            calm_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            freq      <= freq_nxt;
            amp       <= amp_nxt;
            prev_freq <= prev_freq_nxt;
            prev_amp  <= prev_amp_nxt;
            motor_en  <= en_nxt;
            alarm     <= alarm_nxt;
            tick_cnt  <= tick_nxt;
            seen_dal  <= seen_nxt;
            gelijk_s  <= gelijk_nxt;
            calm_cnt  <= calm_nxt;
            fail_cnt  <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        freq_nxt      = freq;
        amp_nxt       = amp;
        prev_freq_nxt = prev_freq;
        prev_amp_nxt  = prev_amp;
        en_nxt        = motor_en;
        alarm_nxt     = alarm;
        tick_nxt      = tick_cnt;
        seen_nxt      = seen_dal;
        gelijk_nxt    = gelijk_s;
        calm_nxt      = calm_cnt;
        fail_nxt      = fail_cnt;
        calm_inc      = sat_inc(calm_cnt);
        fail_inc      = sat_inc(fail_cnt);

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt     = EVAL;
                    freq_nxt      = '0;
                    amp_nxt       = AMP_W'(1);
                    prev_freq_nxt = '0;
                    prev_amp_nxt  = AMP_W'(1);
                    en_nxt        = 1'b1;
                    tick_nxt      = '0;
                    seen_nxt      = 1'b0;
                    calm_nxt      = '0;
                    fail_nxt      = '0;
                end
            end
            EVAL: begin
                if (stop) begin
                    state_nxt = RAMP;
                end else begin
                    if (gedaald) seen_nxt = 1'b1;
                    if (clk12) begin
                        if (tick_cnt == TICK_LAST) begin
                            state_nxt  = DECIDE;
                            gelijk_nxt = gelijk;
                        end else begin
                            tick_nxt = tick_cnt + TICK_W'(1);
                        end
                    end
                end
            end
            DECIDE: begin
                tick_nxt = '0;
                seen_nxt = 1'b0;
                if (stop) begin
                    state_nxt = RAMP;
                end else if (seen_dal) begin
                    fail_nxt  = '0;
                    calm_nxt  = calm_inc;
                    state_nxt = (calm_inc >= CALM_LIM) ? RAMP : EVAL;
                end else if (gelijk_s) begin
                    prev_freq_nxt = freq;
                    prev_amp_nxt  = amp;
                    calm_nxt      = '0;
                    state_nxt     = EVAL;
                    if (amp != AMP_MAX) begin
                        amp_nxt = amp + AMP_W'(1);
                    end else if (freq != FREQ_MAX) begin
                        freq_nxt = freq + FREQ_W'(1);
                        amp_nxt  = AMP_W'(1);
                    end
                end else begin
                    // Stress rose: undo the last advance and count the miss.
                    freq_nxt = prev_freq;
                    amp_nxt  = prev_amp;
                    calm_nxt = '0;
                    fail_nxt = fail_inc;
                    if (fail_inc >= FAIL_LIM) begin
                        state_nxt = ALARM;
                        alarm_nxt = 1'b1;
                        amp_nxt   = '0;
                        en_nxt    = 1'b0;
                    end else begin
                        state_nxt = EVAL;
                    end
                end
            end
            RAMP: begin
                if (clk12 || amp == '0) begin
                    if (amp <= AMP_W'(1)) begin
                        state_nxt = IDLE;
                        amp_nxt   = '0;
                        freq_nxt  = '0;
                        en_nxt    = 1'b0;
                    end else begin
                        amp_nxt = amp - AMP_W'(1);
                    end
                end
            end
            ALARM: begin
                if (stop) begin
                    state_nxt = IDLE;
                    alarm_nxt = 1'b0;
                    freq_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    schommel_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .clk12 (clk12),
        .en    (motor_en),
        .freq  (freq),
        .amp   (amp),
        .pwm   (motor_pwm),
        .dir   (motor_dir)
    );

endmodule
